// File: rtl/inv_mix_columns.sv
// inv_mix_columns: iterative AES InvMixColumns engine, one column per cycle.
// Ports: clk, g_rst_n (async active-low), data_in[127:0], enable (start),
//        data_out[127:0] (held result), busy, done (one-cycle pulse).
module inv_mix_columns (
   input  logic         clk,
   input  logic         g_rst_n,
   input  logic [127:0] data_in,
   input  logic         enable,
   output logic [127:0] data_out,
   output logic         busy,
   output logic         done
);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t        state;
   logic [127:0]  work;
   logic [1:0]    col;

   logic [31:0]   col_in;
   logic [31:0]   col_out;
   logic [127:0]  work_next;

   function automatic logic [7:0] xtime(
      input logic [7:0] x
   );
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   // Column image: row 0 is the most significant byte.
   function automatic logic [31:0] inv_col(
      input logic [31:0] a
   );
      logic [7:0] x  [4];
      logic [7:0] x2 [4];
      logic [7:0] x4 [4];
      logic [7:0] x8 [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] b  [4];
      for (int i = 0; i < 4; i++) begin
         x[i]  = a[31-8*i -: 8];
         x2[i] = xtime(x[i]);
         x4[i] = xtime(x2[i]);
         x8[i] = xtime(x4[i]);
         m9[i] = x8[i] ^ x[i];
         mb[i] = x8[i] ^ x2[i] ^ x[i];
         md[i] = x8[i] ^ x4[i] ^ x[i];
         me[i] = x8[i] ^ x4[i] ^ x2[i];
      end
      b[0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      b[1] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      b[2] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      b[3] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
      return {b[0], b[1], b[2], b[3]};
   endfunction

   // Single shared column transform; col selects which column feeds it.
   always_comb begin
      col_in = work[127:96];
      unique case (col)
         2'd0: col_in = work[127:96];
         2'd1: col_in = work[95:64];
         2'd2: col_in = work[63:32];
         2'd3: col_in = work[31:0];
      endcase
   end

   assign col_out = inv_col(col_in);

   always_comb begin
      work_next = work;
      unique case (col)
         2'd0: work_next[127:96] = col_out;
         2'd1: work_next[95:64]  = col_out;
         2'd2: work_next[63:32]  = col_out;
         2'd3: work_next[31:0]   = col_out;
      endcase
   end

   always_ff @(posedge clk or negedge g_rst_n) begin
      if (!g_rst_n) begin
         state    <= IDLE;
         work     <= '0;
         col      <= 2'd0;
         data_out <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (enable) begin
                  work  <= data_in;
                  col   <= 2'd0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               work <= work_next;
               col  <= col + 2'd1;
               if (col == 2'd3) begin
                  data_out <= work_next;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inv_mix_columns.sv
// tb_inv_mix_columns: directed and randomized checks of inv_mix_columns
// against a GF(2^8) matrix reference model.
module tb_inv_mix_columns;

   logic         clk;
   logic         g_rst_n;
   logic [127:0] data_in;
   logic         enable;
   logic [127:0] data_out;
   logic         busy;
   logic         done;

   int checks;
   int errors;

   inv_mix_columns dut (
      .clk      (clk),
      .g_rst_n  (g_rst_n),
      .data_in  (data_in),
      .enable   (enable),
      .data_out (data_out),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shift-and-add field multiply, reduction polynomial x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gmul(
      input logic [7:0] a,
      input logic [7:0] b
   );
      logic [7:0] p;
      logic [7:0] aa;
      logic [7:0] bb;
      logic       hi;
      p  = 8'h00;
      aa = a;
      bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         hi = aa[7];
         aa = {aa[6:0], 1'b0};
         if (hi) aa = aa ^ 8'h1b;
         bb = bb >> 1;
      end
      return p;
   endfunction

   // Apply a 4x4 circulant matrix (first row given) to every column.
   function automatic logic [127:0] mat_mix(
      input logic [127:0] s,
      input logic [31:0]  row0
   );
      logic [7:0]   r0 [4];
      logic [127:0] o;
      logic [7:0]   acc;
      for (int k = 0; k < 4; k++) r0[k] = row0[31-8*k -: 8];
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++)
               acc = acc ^ gmul(r0[(k - r + 4) % 4], s[127-32*c-8*k -: 8]);
            o[127-32*c-8*r -: 8] = acc;
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] fwd_mix(input logic [127:0] s);
      return mat_mix(s, 32'h02030101);
   endfunction

   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      return mat_mix(s, 32'h0e0b0d09);
   endfunction

   task automatic chk(
      input string        tag,
      input logic [127:0] obs,
      input logic [127:0] exp
   );
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Start one block from idle and check latency, busy span, result.
   task automatic run_block(
      input logic [127:0] d,
      input logic [127:0] exp,
      input string        tag
   );
      logic [127:0] prev;
      int cnt;
      int bcnt;
      @(negedge clk);
      prev    = data_out;
      data_in = d;
      enable  = 1'b1;
      @(negedge clk);
      enable  = 1'b0;
      data_in = '0;
      chk({tag, "_busy_start"}, {127'd0, busy}, 128'd1);
      chk({tag, "_hold"}, data_out, prev);
      cnt  = 0;
      bcnt = 1;
      do begin
         @(negedge clk);
         cnt++;
         if (busy) bcnt++;
      end while (!done && cnt < 10);
      chk({tag, "_latency"}, 128'(cnt), 128'd4);
      chk({tag, "_busy_cycles"}, 128'(bcnt), 128'd4);
      chk({tag, "_data"}, data_out, exp);
      @(negedge clk);
      chk({tag, "_done_drop"}, {127'd0, done}, 128'd0);
   endtask

   initial begin
      logic [127:0] a;
      logic [127:0] b;
      logic [127:0] got;
      logic [127:0] s;
      int dcnt;
      int t1;
      int t2;
      checks  = 0;
      errors  = 0;
      g_rst_n = 1'b0;
      enable  = 1'b0;
      data_in = '0;
      #23;
      chk("rst_data", data_out, 128'd0);
      chk("rst_busy", {127'd0, busy}, 128'd0);
      chk("rst_done", {127'd0, done}, 128'd0);
      @(negedge clk);
      g_rst_n = 1'b1;

      run_block(128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6,
                128'hdb135345_f20a225c_01010101_d4d4d4d5, "fips");
      run_block(128'hc6c6c6c6_4d7ebdf8_00000000_ffffffff,
                128'hc6c6c6c6_2d26314c_00000000_ffffffff, "vec2");

      // Mid-cycle asynchronous reset with no clock edge.
      @(posedge clk);
      #2 g_rst_n = 1'b0;
      #1;
      chk("async_rst_data", data_out, 128'd0);
      chk("async_rst_busy", {127'd0, busy}, 128'd0);
      chk("async_rst_done", {127'd0, done}, 128'd0);
      @(negedge clk);
      g_rst_n = 1'b1;

      // enable during cycles 2 and 3 of a run is ignored.
      a = {$urandom, $urandom, $urandom, $urandom};
      b = ~a;
      @(negedge clk);
      data_in = a;
      enable  = 1'b1;
      @(negedge clk);
      enable  = 1'b0;
      @(negedge clk);
      data_in = b;
      enable  = 1'b1;
      @(negedge clk);
      @(negedge clk);
      enable  = 1'b0;
      data_in = '0;
      dcnt = 0;
      got  = '0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done) begin
            dcnt++;
            got = data_out;
         end
      end
      chk("ignore_done_count", 128'(dcnt), 128'd1);
      chk("ignore_data", got, inv_mix(a));

      // Back-to-back with enable held high.
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      data_in = a;
      enable  = 1'b1;
      @(negedge clk);
      data_in = b;
      t1 = -1;
      t2 = -1;
      for (int i = 1; i <= 12 && t2 < 0; i++) begin
         @(negedge clk);
         if (done) begin
            if (t1 < 0) begin
               t1 = i;
               chk("b2b_first", data_out, inv_mix(a));
            end else begin
               t2 = i;
               enable = 1'b0;
               chk("b2b_second", data_out, inv_mix(b));
            end
         end
      end
      enable = 1'b0;
      chk("b2b_first_latency", 128'(t1), 128'd4);
      chk("b2b_spacing", 128'(t2 - t1), 128'd5);
      dcnt = 0;
      while (busy && dcnt < 10) begin
         @(negedge clk);
         dcnt++;
      end
      chk("b2b_idle", {127'd0, busy}, 128'd0);

      // Reset abort while col=2 is pending.
      @(negedge clk);
      data_in = {$urandom, $urandom, $urandom, $urandom};
      enable  = 1'b1;
      @(negedge clk);
      enable  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1 g_rst_n = 1'b0;
      #1;
      chk("abort_data", data_out, 128'd0);
      chk("abort_busy", {127'd0, busy}, 128'd0);
      @(negedge clk);
      g_rst_n = 1'b1;
      dcnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      chk("abort_no_done", 128'(dcnt), 128'd0);
      chk("abort_data_hold", data_out, 128'd0);
      a = {$urandom, $urandom, $urandom, $urandom};
      run_block(a, inv_mix(a), "after_abort");

      // Round trip through the forward mixer.
      for (int n = 0; n < 1000; n++) begin
         s = {$urandom, $urandom, $urandom, $urandom};
         run_block(fwd_mix(s), s, "roundtrip");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/inv_mix_columns.md
# inv_mix_columns

Iterative AES InvMixColumns engine for the CAN-SEC decryption datapath. It is the receive-side counterpart of the encrypt-side column mixer. The block accepts a 128-bit AES state on a start pulse and transforms one 32-bit column per clock using GF(2^8) multiplication by 0x09, 0x0B, 0x0D and 0x0E. It then presents the registered result with a one-cycle done pulse. It sits between InvShiftRows/InvSubBytes and AddRoundKey in the inverse round sequencer.

## Interface
- No parameters; the state width is fixed at 128 bits and the column count is fixed at 4.
- clk  input  1  rising-edge clock
- g_rst_n  input  1  asynchronous, active-low reset
- data_in  input  128  AES state. Byte order matches the encrypt path: column c occupies bits [127-32c -: 32], and row 0 of each column is the most significant byte.
- enable  input  1  start request; sampled only while idle
- data_out  output  128  InvMixColumns result; held until the next completion
- busy  output  1  high while a transform is in progress
- done  output  1  one-cycle pulse when data_out is updated

## Operation
- Two states: IDLE and RUN. Internal registers: 128-bit working state, 2-bit column counter col.
- IDLE:
  - On enable=1: load data_in into the working state, set col=0 and busy=1, go to RUN.
  - On enable=0: hold.
- RUN, each cycle:
  - Replace column col of the working state with its InvMixColumns image, then increment col.
  - When col=3 is processed: write the final 128-bit state to data_out, pulse done=1, clear busy, go to IDLE.
- Column math, with input bytes a0..a3 and output bytes b0..b3:
  - b0 = 0E·a0 ^ 0B·a1 ^ 0D·a2 ^ 09·a3
  - b1 = 09·a0 ^ 0E·a1 ^ 0B·a2 ^ 0D·a3
  - b2 = 0D·a0 ^ 09·a1 ^ 0E·a2 ^ 0B·a3
  - b3 = 0B·a0 ^ 0D·a1 ^ 09·a2 ^ 0E·a3
- GF arithmetic:
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00).
  - Build x2, x4 and x8 by chaining xtime.
  - 09=x8^x; 0B=x8^x2^x; 0D=x8^x4^x; 0E=x8^x4^x2.
  - All results are 8 bits; no carries leave a byte.
- Only one column-transform instance is shared across all four cycles; a mux selects the column by col.
- enable while busy=1 is ignored: no restart, no queueing, and data_in is not resampled.
- data_in only needs to be stable in the cycle enable is sampled.

## Timing
- Reset (g_rst_n=0, asynchronous):
  - data_out=0, busy=0, done=0.
  - Working state and col are cleared; state goes to IDLE.
- Reset asserted mid-transform: the operation is abandoned, no done is produced, and data_out reads 0.
- Latency:
  - enable is sampled at edge E0.
  - Columns 0..3 are processed at edges E1..E4.
  - data_out and done=1 are registered at E4.
  - done drops at E5 unless a new completion occurs.
- busy is high from after E0 through E4, and low in the cycle done is high.
- Back-to-back: enable high during the done cycle is accepted at E5, giving a throughput of 1 block per 5 cycles.
- data_out changes only at a completion edge. It is stable between completions, and also during a following transform.
- enable held continuously high: a new transform starts every 5 cycles.

## Test plan
- Reset values: assert g_rst_n=0 mid-cycle with no clock edge -> data_out=0, busy=0, done=0 immediately.
- FIPS-197 columns: enable with data_in=128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6 -> after exactly 4 further edges data_out=128'hdb135345_f20a225c_01010101_d4d4d4d5, done high for one cycle, busy high for 4 cycles.
- Second vector and byte order: data_in=128'hc6c6c6c6_4d7ebdf8_00000000_ffffffff -> data_out=128'hc6c6c6c6_2d26314c_00000000_ffffffff.
- Busy-ignore: pulse enable again with different data during cycles 2 and 3 of a run -> the result equals the first input's transform; only one done pulse occurs.
- Back-to-back and reset abort:
  - Hold enable=1 over two blocks -> done pulses 5 cycles apart with correct results each time.
  - Deassert g_rst_n during col=2 -> no done pulse, data_out=0, and the next enable completes normally.
- Round trip: 1000 random 128-bit states passed through the encrypt-side column mixer, then through this block -> the original state is returned in every case.
